// File: rtl/fluid_tank_emulator.sv
// -----------------------------------------------------------------------------
// fluid_tank_emulator
//
// Register-mapped tank model for hardware-in-the-loop bring-up of the fluid
// level indicator. Software selects FILL / DRAIN / HOLD and a step period; the
// block steps a 0..8 level counter and drives its thermometer code onto the
// eight level-sensor lines. FULL / EMPTY flags raise an interrupt when enabled.
//
// Ports:
//   clk         100 MHz system clock
//   rst_n       asynchronous active-low reset
//   wr_addr     write byte address (bits [1:0] ignored)
//   wr_en       write enable, single-cycle pulse
//   wr_data     write data
//   wr_strb     byte enables for wr_data
//   rd_addr     read byte address (bits [1:0] ignored)
//   rd_en       read enable
//   rd_data     combinational read data, 0 when idle or unmapped
//   sensor_out  registered thermometer code, bit i = (level > i)
//   irq         |(IFR & IER)
//
// Register map:
//   0x00 CTRL  [1:0] STATE (00 HOLD, 01 FILL, 10 DRAIN, 11 -> HOLD)
//              [2] BOUNCE, [4:3] IER {EMPTY, FULL}
//   0x04 RATE  [23:0] step period, one step every RATE+1 clocks
//   0x08 STAT  [3:0] LEVEL, [9:8] IFR {EMPTY, FULL}; W1C on [9:8]
//   0x0C FAULT [7:0] XOR mask on sensor_out (only with FLUID_EMU_FAULT_EN)
//
// Build option: define FLUID_EMU_FAULT_EN to add the FAULT register.
// -----------------------------------------------------------------------------
module fluid_tank_emulator #(
  parameter logic [23:0] RATE_DEFAULT = 24'd9999999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  wr_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic [3:0]  rd_addr,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic [7:0]  sensor_out,
  output logic        irq
);

  localparam logic [1:0] StHold  = 2'b00;
  localparam logic [1:0] StFill  = 2'b01;
  localparam logic [1:0] StDrain = 2'b10;

  localparam logic [1:0] AddrCtrl  = 2'd0;
  localparam logic [1:0] AddrRate  = 2'd1;
  localparam logic [1:0] AddrStat  = 2'd2;
  localparam logic [1:0] AddrFault = 2'd3;

  // Flag bit positions inside ifr/ier
  localparam int unsigned FlagFull  = 0;
  localparam int unsigned FlagEmpty = 1;

  logic [1:0]  state_q, state_d;
  logic        bounce_q, bounce_d;
  logic [1:0]  ier_q, ier_d;
  logic [1:0]  ifr_q, ifr_d;
  logic [23:0] rate_q, rate_d;
  logic [23:0] div_q, div_d;
  logic [3:0]  level_q, level_d;
  logic [7:0]  sensor_q, sensor_d;
  logic [7:0]  thermo;
  logic [7:0]  fault_mask;

  logic        wr_ctrl, wr_rate, wr_stat;
  logic        ctrl_state_wr, rate_reload;
  logic        tick;
  logic [1:0]  ifr_set, ifr_clr;

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ctrl       = wr_en && (wr_addr[3:2] == AddrCtrl);
    wr_rate       = wr_en && (wr_addr[3:2] == AddrRate);
    wr_stat       = wr_en && (wr_addr[3:2] == AddrStat);
    // All CTRL fields live in byte 0, so only that strobe matters.
    ctrl_state_wr = wr_ctrl && wr_strb[0];
    // RATE has no storage in byte 3; a write touching only byte 3 is a no-op.
    rate_reload   = wr_rate && (|wr_strb[2:0]);
  end

  always_comb begin
    rate_d = rate_q;
    if (wr_rate) begin
      for (int b = 0; b < 3; b++) begin
        if (wr_strb[b]) begin
          rate_d[8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Step divider and level FSM
  // ---------------------------------------------------------------------------
  assign tick = (div_q == 24'd0) && (state_q != StHold);

  always_comb begin
    level_d  = level_q;
    state_d  = state_q;
    bounce_d = bounce_q;
    ier_d    = ier_q;
    ifr_set  = 2'b00;

    if (tick) begin
      case (state_q)
        StFill: begin
          if (level_q < 4'd8) begin
            level_d = level_q + 4'd1;
            // Direction changes on the same edge as the step that hits the top.
            if (level_q == 4'd7) begin
              ifr_set[FlagFull] = 1'b1;
              state_d           = bounce_q ? StDrain : StHold;
            end
          end else begin
            // Entered FILL already full: park without a step or a flag.
            state_d = StHold;
          end
        end
        StDrain: begin
          if (level_q > 4'd0) begin
            level_d = level_q - 4'd1;
            if (level_q == 4'd1) begin
              ifr_set[FlagEmpty] = 1'b1;
              state_d            = bounce_q ? StFill : StHold;
            end
          end else begin
            state_d = StHold;
          end
        end
        default: ;
      endcase
    end

    // Software write wins over any automatic transition this cycle.
    if (ctrl_state_wr) begin
      state_d  = (wr_data[1:0] == 2'b11) ? StHold : wr_data[1:0];
      bounce_d = wr_data[2];
      ier_d    = wr_data[4:3];
    end
  end

  always_comb begin
    if (tick || ctrl_state_wr || rate_reload) begin
      // Reload from the post-write RATE so a new period takes effect at once.
      div_d = rate_d;
    end else if (state_q != StHold) begin
      div_d = div_q - 24'd1;
    end else begin
      div_d = div_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt flags: set wins over a simultaneous W1C clear
  // ---------------------------------------------------------------------------
  assign ifr_clr = (wr_stat && wr_strb[1]) ? wr_data[9:8] : 2'b00;
  assign ifr_d   = (ifr_q & ~ifr_clr) | ifr_set;

  // ---------------------------------------------------------------------------
  // Sensor code
  // ---------------------------------------------------------------------------
  always_comb begin
    thermo = 8'h00;
    for (int i = 0; i < 8; i++) begin
      thermo[i] = (level_q > 4'(i));
    end
  end

`ifdef FLUID_EMU_FAULT_EN
  logic [7:0] fault_q, fault_d;
  logic       wr_fault;

  assign wr_fault   = wr_en && (wr_addr[3:2] == AddrFault);
  assign fault_d    = (wr_fault && wr_strb[0]) ? wr_data[7:0] : fault_q;
  assign fault_mask = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 8'h00;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  assign fault_mask = 8'h00;
`endif

  assign sensor_d = thermo ^ fault_mask;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StHold;
      bounce_q <= 1'b0;
      ier_q    <= 2'b00;
      ifr_q    <= 2'b00;
      rate_q   <= RATE_DEFAULT;
      div_q    <= RATE_DEFAULT;
      level_q  <= 4'd0;
      sensor_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      bounce_q <= bounce_d;
      ier_q    <= ier_d;
      ifr_q    <= ifr_d;
      rate_q   <= rate_d;
      div_q    <= div_d;
      level_q  <= level_d;
      sensor_q <= sensor_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sensor_out = sensor_q;
  assign irq        = |(ifr_q & ier_q);

  always_comb begin
    rd_data = 32'h0000_0000;
    if (rd_en) begin
      case (rd_addr[3:2])
        AddrCtrl:  rd_data = {27'd0, ier_q, bounce_q, state_q};
        AddrRate:  rd_data = {8'd0, rate_q};
        AddrStat:  rd_data = {22'd0, ifr_q, 4'd0, level_q};
`ifdef FLUID_EMU_FAULT_EN
        AddrFault: rd_data = {24'd0, fault_mask};
`endif
        default:   rd_data = 32'h0000_0000;
      endcase
    end
  end

  // Address LSBs, RATE's top byte and its strobe carry no storage.
  logic unused_bits;
  assign unused_bits = ^{wr_addr[1:0], rd_addr[1:0], wr_data[31:24], wr_strb[3]};

endmodule

// File: tb/tb_fluid_tank_emulator.sv
module tb_fluid_tank_emulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic [3:0]  wr_strb = 4'd0;
  logic [3:0]  rd_addr = 4'd0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic [7:0]  sensor_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fluid_tank_emulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_addr    (wr_addr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_strb    (wr_strb),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .sensor_out (sensor_out),
    .irq        (irq)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tank model: state kept as plain integers, advanced once per clock
  // ---------------------------------------------------------------------------
  int        m_level;
  int        m_mode;    // 0 hold, 1 fill, 2 drain
  bit        m_bounce;
  bit [1:0]  m_ier;     // [0] full, [1] empty
  bit [1:0]  m_ifr;
  bit [23:0] m_rate;
  int        m_wait;    // clocks left before the next step
  bit [7:0]  m_sensor;
  bit [7:0]  m_fault;

  function automatic bit [7:0] therm(input int lvl);
    bit [7:0] t = 8'h00;
    for (int i = 0; i < 8; i++) if (lvl > i) t[i] = 1'b1;
    return t;
  endfunction

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    case (a[3:2])
      2'd0: return 32'(m_mode) | (32'(m_bounce) << 2) | (32'(m_ier) << 3);
      2'd1: return 32'(m_rate);
      2'd2: return 32'(m_level) | (32'(m_ifr) << 8);
`ifdef FLUID_EMU_FAULT_EN
      default: return 32'(m_fault);
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  task automatic model_reset();
    m_level = 0; m_mode = 0; m_bounce = 0; m_ier = 0; m_ifr = 0;
    m_rate = 24'd9999999; m_wait = 9999999; m_sensor = 0; m_fault = 0;
  endtask

  task automatic model_step();
    int        lvl = m_level;
    int        mode = m_mode;
    int        wt = m_wait;
    bit [23:0] rate = m_rate;
    bit [1:0]  setf = 2'b00;
    bit [1:0]  clr = 2'b00;
    bit [1:0]  reg_sel = wr_addr[3:2];

    m_sensor = therm(m_level) ^ m_fault;

    if (wr_en && reg_sel == 2'd1)
      for (int b = 0; b < 3; b++) if (wr_strb[b]) rate[8*b +: 8] = wr_data[8*b +: 8];

    if (m_mode != 0 && wt == 0) begin
      if (mode == 1) begin
        if (lvl == 8) mode = 0;
        else begin
          lvl++;
          if (lvl == 8) begin setf[0] = 1; mode = m_bounce ? 2 : 0; end
        end
      end else begin
        if (lvl == 0) mode = 0;
        else begin
          lvl--;
          if (lvl == 0) begin setf[1] = 1; mode = m_bounce ? 1 : 0; end
        end
      end
      wt = int'(rate);
    end else if (m_mode != 0) begin
      wt--;
    end

    if (wr_en && reg_sel == 2'd0 && wr_strb[0]) begin
      mode     = (wr_data[1:0] == 2'b11) ? 0 : int'(wr_data[1:0]);
      m_bounce = wr_data[2];
      m_ier    = wr_data[4:3];
      wt       = int'(rate);
    end
    if (wr_en && reg_sel == 2'd1 && |wr_strb[2:0]) wt = int'(rate);
    if (wr_en && reg_sel == 2'd2 && wr_strb[1]) clr = wr_data[9:8];
`ifdef FLUID_EMU_FAULT_EN
    if (wr_en && reg_sel == 2'd3 && wr_strb[0]) m_fault = wr_data[7:0];
`endif

    m_ifr   = (m_ifr & ~clr) | setf;
    m_level = lvl;
    m_mode  = mode;
    m_wait  = wt;
    m_rate  = rate;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Compare DUT against the model on every falling edge out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      check("sensor_out", 32'(sensor_out), 32'(m_sensor));
      check("irq", 32'(irq), 32'(|(m_ifr & m_ier)));
      check("rd_data", rd_data, rd_en ? exp_read(rd_addr) : 32'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers (called at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_strb = 4'd0; wr_data = 32'd0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1; rd_addr = 4'(i * 4);
      @(posedge clk); #1;
    end
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a; #1;
    check(name, rd_data, exp);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sensor", 32'(sensor_out), 32'h00);
    check("rst_irq", 32'(irq), 32'd0);
    rd_chk("rst_rate", 4'h4, 32'h0098_967F);
    rd_chk("rst_ctrl", 4'h0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: FILL at RATE=3, one step every 4 clocks
    wr(4'h4, 32'd3, 4'hF);
    wr(4'h0, 32'h1, 4'h1);
    wait_cycles(4);
    rd_chk("t1_level1", 4'h8, 32'h001);
    check("t1_sensor_lag", 32'(sensor_out), 32'h00);
    wait_cycles(1);
    check("t1_sensor01", 32'(sensor_out), 32'h01);
    wait_cycles(35);
    rd_chk("t1_stat_full", 4'h8, 32'h108);
    rd_chk("t1_ctrl_hold", 4'h0, 32'h0);
    check("t1_sensor_ff", 32'(sensor_out), 32'hFF);

    // 2: enable FULL interrupt, then W1C
    wr(4'h0, 32'h08, 4'h1);
    check("t2_irq_on", 32'(irq), 32'd1);
    wr(4'h8, 32'h100, 4'b0010);
    check("t2_irq_off", 32'(irq), 32'd0);
    rd_chk("t2_stat", 4'h8, 32'h008);

    // 3: bounce sweep at RATE=0
    wr(4'h4, 32'd0, 4'hF);
    wr(4'h0, 32'h2, 4'h1);
    wait_cycles(10);
    rd_chk("t3_empty", 4'h8, 32'h200);
    wr(4'h8, 32'h300, 4'b0010);
    wr(4'h0, 32'h1D, 4'h1);
    wait_cycles(8);
    rd_chk("t3_ctrl_drain", 4'h0, 32'h1E);
    rd_chk("t3_stat_top", 4'h8, 32'h108);
    check("t3_irq", 32'(irq), 32'd1);
    wait_cycles(8);
    rd_chk("t3_ctrl_fill", 4'h0, 32'h1D);
    rd_chk("t3_stat_bottom", 4'h8, 32'h300);
    wr(4'h0, 32'h0, 4'h1);
    wr(4'h0, 32'h2, 4'h1);
    wait_cycles(3);
    wr(4'h8, 32'h300, 4'b0010);
    rd_chk("t3_cleared", 4'h8, 32'h000);

    // 4: W1C FULL on the same edge as the 7->8 step
    wr(4'h0, 32'h1, 4'h1);
    wait_cycles(7);
    wr(4'h8, 32'h100, 4'b0010);
    rd_chk("t4_set_wins", 4'h8, 32'h108);

    // 5: byte strobes
    wr(4'h0, 32'h2, 4'h0);
    wait_cycles(2);
    rd_chk("t5_ctrl_nostrb", 4'h0, 32'h0);
    rd_chk("t5_level_held", 4'h8, 32'h108);
    wr(4'h4, 32'h00AB_CDEF, 4'b0001);
    rd_chk("t5_rate_byte0", 4'h4, 32'h0000_00EF);

    // 6: FAULT register at level 3
    wr(4'h4, 32'd0, 4'hF);
    wr(4'h0, 32'h2, 4'h1);
    wait_cycles(4);
    wr(4'h0, 32'h0, 4'h1);
    wr(4'hC, 32'h10, 4'h1);
    wait_cycles(2);
    rd_chk("t6_level3", 4'h8, 32'h103);
`ifdef FLUID_EMU_FAULT_EN
    check("t6_sensor", 32'(sensor_out), 32'h17);
    rd_chk("t6_fault_rd", 4'hC, 32'h10);
`else
    check("t6_sensor", 32'(sensor_out), 32'h07);
    rd_chk("t6_fault_rd", 4'hC, 32'h0);
`endif

    // 7: asynchronous reset in the middle of a sweep
    wr(4'h0, 32'h1, 4'h1);
    wait_cycles(2);
    #2 rst_n = 1'b0;
    #1;
    check("t7_sensor", 32'(sensor_out), 32'h00);
    check("t7_irq", 32'(irq), 32'd0);
    rd_chk("t7_stat", 4'h8, 32'h000);
    rd_chk("t7_rate", 4'h4, 32'h0098_967F);
    rd_chk("t7_ctrl", 4'h0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_cycles(4);
    rd_chk("t7_stays", 4'h8, 32'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
